// File: rtl/mem_wb_writeback_pkg.sv
// Shared types and constants for the MEM/WB writeback slice.
package wb_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;

   // Register 0 is hardwired to zero, so it is never written.
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wb_state_e;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// Retiring-instruction handshake, load-data return and register-file write bus.
interface mem_wb_writeback_if
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rd;
   logic              in_regwrite;
   logic              in_memtoreg;
   logic [DATA_W-1:0] in_aluresult;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] writedata;
   logic              regwrite;
   logic              timeout_err;
   logic [31:0]       retired;
   logic              fwd_valid;
   logic [ADDR_W-1:0] fwd_rd;
   logic [DATA_W-1:0] fwd_data;

   modport master (
      output in_valid, in_rd, in_regwrite, in_memtoreg, in_aluresult, mem_rdata, mem_rvalid,
      input  in_ready, rd, writedata, regwrite, timeout_err, retired, fwd_valid, fwd_rd, fwd_data
   );

   modport slave (
      input  in_valid, in_rd, in_regwrite, in_memtoreg, in_aluresult, mem_rdata, mem_rvalid,
      output in_ready, rd, writedata, regwrite, timeout_err, retired, fwd_valid, fwd_rd, fwd_data
   );

endinterface

// File: rtl/mem_wb_writeback_timeout_counter.sv
// Load-wait cycle counter: cleared when a load is accepted, counts each idle wait cycle,
// flags the last permitted wait cycle.
module wb_timeout_counter
   import wb_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB writeback stage: accepts one retiring instruction per handshake, selects ALU result
// or load data, and drives the register-file write port with a one-cycle strobe.
// Optional EX bypass outputs are enabled by defining WB_FORWARD_EN.
module mem_wb_writeback
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input logic               clk,
   input logic               rst,
   mem_wb_writeback_if.slave bus
);

   localparam logic [ADDR_W-1:0] RD_ZERO = ADDR_W'(REG_ZERO);

   wb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] writedata_q, writedata_d;
   logic [ADDR_W-1:0] pend_rd_q, pend_rd_d;
   logic              pend_rw_q, pend_rw_d;
   logic              regwrite_q, regwrite_d;
   logic              timeout_err_q, timeout_err_d;
   logic [31:0]       retired_q, retired_d;

   logic in_ready;
   logic accept;
   logic cnt_clear;
   logic cnt_en;
   logic cnt_expired;

   assign in_ready = (state_q != WAIT_MEM);
   assign accept   = bus.in_valid && in_ready;

   wb_timeout_counter #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .expired (cnt_expired)
   );

   // Next-state and write decision. The write strobe and retired count are registered on the
   // edge that enters WRITE, so they appear together with rd/writedata during the WRITE cycle.
   // Load fields park in pend_* so rd/writedata only change on entering WRITE.
   always_comb begin
      state_d       = state_q;
      rd_d          = rd_q;
      writedata_d   = writedata_q;
      pend_rd_d     = pend_rd_q;
      pend_rw_d     = pend_rw_q;
      regwrite_d    = 1'b0;
      timeout_err_d = 1'b0;
      retired_d     = retired_q;
      cnt_clear     = 1'b0;
      cnt_en        = 1'b0;
      case (state_q)
         IDLE, WRITE: begin
            state_d = IDLE;
            if (accept) begin
               if (bus.in_memtoreg) begin
                  pend_rd_d = bus.in_rd;
                  pend_rw_d = bus.in_regwrite;
                  cnt_clear = 1'b1;
                  state_d   = WAIT_MEM;
               end else begin
                  rd_d        = bus.in_rd;
                  writedata_d = bus.in_aluresult;
                  state_d     = WRITE;
                  if (bus.in_regwrite && (bus.in_rd != RD_ZERO)) begin
                     regwrite_d = 1'b1;
                     retired_d  = retired_q + 32'd1;
                  end
               end
            end
         end
         WAIT_MEM: begin
            // Returning data beats a simultaneous timeout.
            if (bus.mem_rvalid) begin
               rd_d        = pend_rd_q;
               writedata_d = bus.mem_rdata;
               state_d     = WRITE;
               if (pend_rw_q && (pend_rd_q != RD_ZERO)) begin
                  regwrite_d = 1'b1;
                  retired_d  = retired_q + 32'd1;
               end
            end else if (cnt_expired) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rd_q          <= '0;
         writedata_q   <= '0;
         pend_rd_q     <= '0;
         pend_rw_q     <= 1'b0;
         regwrite_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         retired_q     <= '0;
      end else begin
         state_q       <= state_d;
         rd_q          <= rd_d;
         writedata_q   <= writedata_d;
         pend_rd_q     <= pend_rd_d;
         pend_rw_q     <= pend_rw_d;
         regwrite_q    <= regwrite_d;
         timeout_err_q <= timeout_err_d;
         retired_q     <= retired_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.rd          = rd_q;
   assign bus.writedata   = writedata_q;
   assign bus.regwrite    = regwrite_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.retired     = retired_q;

`ifdef WB_FORWARD_EN
   assign bus.fwd_valid = regwrite_q;
   assign bus.fwd_rd    = rd_q;
   assign bus.fwd_data  = writedata_q;
`else
   assign bus.fwd_valid = 1'b0;
   assign bus.fwd_rd    = '0;
   assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback against a transaction-level writeback model.
module tb_mem_wb_writeback;
   import wb_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned TO = 16;
`ifdef WB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   mem_wb_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

   mem_wb_writeback #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          in_ready;
      logic          regwrite;
      logic          timeout_err;
      logic [AW-1:0] rd;
      logic [DW-1:0] wd;
      logic [31:0]   retired;
      logic          fv;
      logic [AW-1:0] frd;
      logic [DW-1:0] fd;
   } obs_t;

   // Architectural view: last written register/data and number of real writes.
   logic [AW-1:0] m_rd;
   logic [DW-1:0] m_wd;
   logic [31:0]   m_retired;

   function automatic obs_t observe();
      obs_t o;
      o.in_ready    = ifc.in_ready;
      o.regwrite    = ifc.regwrite;
      o.timeout_err = ifc.timeout_err;
      o.rd          = ifc.rd;
      o.wd          = ifc.writedata;
      o.retired     = ifc.retired;
      o.fv          = ifc.fwd_valid;
      o.frd         = ifc.fwd_rd;
      o.fd          = ifc.fwd_data;
      return o;
   endfunction

   function automatic obs_t expect_obs(logic ready, logic wr, logic to);
      obs_t e;
      e.in_ready    = ready;
      e.regwrite    = wr;
      e.timeout_err = to;
      e.rd          = m_rd;
      e.wd          = m_wd;
      e.retired     = m_retired;
      e.fv          = FWD ? wr : 1'b0;
      e.frd         = FWD ? m_rd : '0;
      e.fd          = FWD ? m_wd : '0;
      return e;
   endfunction

   // An instruction that reaches WRITE: a real write only when enabled and not r0.
   function automatic bit model_commit(logic [AW-1:0] rd, logic [DW-1:0] data, logic rw);
      m_rd = rd;
      m_wd = data;
      if (rw && rd != 0) begin
         m_retired = m_retired + 1;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifc.in_valid     = 1'b0;
      ifc.in_rd        = '0;
      ifc.in_regwrite  = 1'b0;
      ifc.in_memtoreg  = 1'b0;
      ifc.in_aluresult = '0;
      ifc.mem_rdata    = '0;
      ifc.mem_rvalid   = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o, e;
      ifc.in_valid     = 1'b1;
      ifc.in_rd        = AW'($urandom);
      ifc.in_regwrite  = 1'b1;
      ifc.in_memtoreg  = 1'b0;
      ifc.in_aluresult = $urandom;
      ifc.mem_rvalid   = 1'b1;
      ifc.mem_rdata    = $urandom;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      idle_inputs();
      m_rd = '0; m_wd = '0; m_retired = '0;
      o = observe(); e = expect_obs(1'b1, 1'b0, 1'b0);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", o, e);
      end
   endtask

   task automatic do_alu(logic [AW-1:0] rd, logic rw, logic [DW-1:0] data);
      obs_t o, e;
      bit wr;
      ifc.in_valid     = 1'b1;
      ifc.in_rd        = rd;
      ifc.in_regwrite  = rw;
      ifc.in_memtoreg  = 1'b0;
      ifc.in_aluresult = data;
      ifc.mem_rvalid   = 1'($urandom);
      ifc.mem_rdata    = $urandom;
      tick();
      ifc.in_valid   = 1'b0;
      ifc.mem_rvalid = 1'b0;
      wr = model_commit(rd, data, rw);
      o = observe(); e = expect_obs(1'b1, wr, 1'b0);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL alu_write rd=%0d got=%h exp=%h", rd, o, e);
      end
   endtask

   task automatic do_load(logic [AW-1:0] rd, logic rw, logic [DW-1:0] data, int delay, bit fire);
      obs_t o, e;
      bit wr;
      bit fired;
      fired = 1'b0;
      ifc.in_valid     = 1'b1;
      ifc.in_rd        = rd;
      ifc.in_regwrite  = rw;
      ifc.in_memtoreg  = 1'b1;
      ifc.in_aluresult = $urandom;
      ifc.mem_rvalid   = 1'b0;
      tick();
      for (int i = 0; i < int'(TO); i++) begin
         // Stray requests while waiting must not be taken.
         ifc.in_valid     = 1'($urandom);
         ifc.in_rd        = AW'($urandom);
         ifc.in_regwrite  = 1'($urandom);
         ifc.in_memtoreg  = 1'($urandom);
         ifc.in_aluresult = $urandom;
         o = observe(); e = expect_obs(1'b0, 1'b0, 1'b0);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL load_wait cyc=%0d got=%h exp=%h", i, o, e);
         end
         if (fire && i == delay) begin
            ifc.mem_rvalid = 1'b1;
            ifc.mem_rdata  = data;
         end else begin
            ifc.mem_rvalid = 1'b0;
            ifc.mem_rdata  = $urandom;
         end
         tick();
         if (fire && i == delay) begin
            fired = 1'b1;
            break;
         end
      end
      ifc.in_valid   = 1'b0;
      ifc.mem_rvalid = 1'b0;
      if (fired) begin
         wr = model_commit(rd, data, rw);
         o = observe(); e = expect_obs(1'b1, wr, 1'b0);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL load_write rd=%0d delay=%0d got=%h exp=%h", rd, delay, o, e);
         end
      end else begin
         o = observe(); e = expect_obs(1'b1, 1'b0, 1'b1);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL load_timeout got=%h exp=%h", o, e);
         end
         tick();
         o = observe(); e = expect_obs(1'b1, 1'b0, 1'b0);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL timeout_pulse_end got=%h exp=%h", o, e);
         end
      end
   endtask

   task automatic test_idle_rvalid(int n);
      obs_t o, e;
      for (int i = 0; i < n; i++) begin
         ifc.in_valid   = 1'b0;
         ifc.mem_rvalid = 1'($urandom);
         ifc.mem_rdata  = $urandom;
         tick();
         o = observe(); e = expect_obs(1'b1, 1'b0, 1'b0);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL idle_rvalid cyc=%0d got=%h exp=%h", i, o, e);
         end
      end
      ifc.mem_rvalid = 1'b0;
   endtask

   task automatic test_alu();
      do_alu(5'd5, 1'b1, 32'h0000_1234);
      for (int i = 0; i < 12; i++) do_alu(AW'($urandom), 1'($urandom), $urandom);
   endtask

   task automatic test_load();
      do_load(5'd8, 1'b1, 32'hDEAD_BEEF, 3, 1'b1);
      for (int i = 0; i < 6; i++)
         do_load(AW'($urandom), 1'($urandom), $urandom, int'($urandom_range(TO - 1, 0)), 1'b1);
   endtask

   task automatic test_rd_zero();
      do_alu(5'd0, 1'b1, 32'h0000_FFFF);
      do_alu(5'd7, 1'b0, 32'h0BAD_0BAD);
      do_load(5'd0, 1'b1, 32'h1357_9BDF, 1, 1'b1);
      do_load(5'd9, 1'b0, 32'h2468_ACE0, 0, 1'b1);
   endtask

   task automatic test_timeout();
      do_load(5'd11, 1'b1, 32'h0, 0, 1'b0);
      do_load(5'd10, 1'b1, 32'hCAFE_F00D, int'(TO) - 1, 1'b1);
      do_load(5'd12, 1'b1, 32'hA5A5_5A5A, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      test_reset();
      do_alu(5'd1, 1'b1, 32'h1111_1111);
      do_alu(5'd2, 1'b1, 32'h2222_2222);
      do_alu(5'd3, 1'b1, 32'h3333_3333);
      checks++;
      if (ifc.retired !== 32'd3) begin
         failures++;
         $display("FAIL back_to_back_retired got=%0d exp=3", ifc.retired);
      end
      // Load immediately following an ALU write is accepted from WRITE.
      do_load(5'd4, 1'b1, 32'h4444_4444, 2, 1'b1);
      do_alu(5'd6, 1'b1, 32'h6666_6666);
   endtask

   task automatic test_rst_mid_load();
      obs_t o, e;
      do_alu(5'd13, 1'b1, 32'h1313_1313);
      ifc.in_valid    = 1'b1;
      ifc.in_rd       = 5'd14;
      ifc.in_regwrite = 1'b1;
      ifc.in_memtoreg = 1'b1;
      tick();
      ifc.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifc.mem_rvalid = 1'b1;
      ifc.mem_rdata  = 32'h7777_7777;
      m_rd = '0; m_wd = '0; m_retired = '0;
      o = observe(); e = expect_obs(1'b1, 1'b0, 1'b0);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL rst_mid_load got=%h exp=%h", o, e);
      end
      tick();
      ifc.mem_rvalid = 1'b0;
      o = observe(); e = expect_obs(1'b1, 1'b0, 1'b0);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL rst_mid_load_after got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_random_mix();
      int kind;
      for (int i = 0; i < 30; i++) begin
         kind = int'($urandom_range(3, 0));
         case (kind)
            0, 1: do_alu(AW'($urandom), 1'($urandom), $urandom);
            2: do_load(AW'($urandom), 1'($urandom), $urandom,
                       int'($urandom_range(TO - 1, 0)), ($urandom_range(7, 0) != 0));
            default: test_idle_rvalid(int'($urandom_range(3, 1)));
         endcase
      end
   endtask

   initial begin
      idle_inputs();
      m_rd = '0; m_wd = '0; m_retired = '0;
      test_reset();
      test_alu();
      test_idle_rvalid(4);
      test_load();
      test_rd_zero();
      test_timeout();
      test_back_to_back();
      test_rst_mid_load();
      test_random_mix();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
